// File: rtl/struct_unpacker.sv
// Struct unpacker: buffers packed {last, first} words in a small FIFO and emits each word as two field beats.
// Optional STRUCT_UNPACKER_LAST_FIRST_EN swaps the beat order (last field first); out_last still marks the second beat.
module struct_unpacker #(
    parameter int FIELD_W = 2,
    parameter int DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*FIELD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FIELD_W-1:0]   out_data,
    output logic                 out_last
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never waits on ready, and in_ready depends only on registered state and rst.
    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_t;

    phase_t                 phase;
    phase_t                 phase_nxt;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [2*FIELD_W-1:0]   mem [DEPTH];
    logic [2*FIELD_W-1:0]   head;
    logic [FIELD_W-1:0]     field_a;
    logic [FIELD_W-1:0]     field_b;
    logic                   push;
    logic                   beat;
    logic                   pop;

    assign in_ready  = (count != CW'(DEPTH)) && !rst;
    assign out_valid = (count != '0) && !rst;
    assign push      = in_valid && in_ready;
    assign beat      = out_valid && out_ready;
    assign pop       = beat && (phase == PH_B);
    assign head      = mem[rd_ptr];

`ifdef STRUCT_UNPACKER_LAST_FIRST_EN
    assign field_a = head[2*FIELD_W-1:FIELD_W];
    assign field_b = head[FIELD_W-1:0];
`else
    assign field_a = head[FIELD_W-1:0];
    assign field_b = head[2*FIELD_W-1:FIELD_W];
`endif

    always_comb begin
        phase_nxt = phase;
        out_data  = '0;
        out_last  = 1'b0;
        if (beat) begin
            phase_nxt = (phase == PH_A) ? PH_B : PH_A;
        end
        if (out_valid) begin
            out_data = (phase == PH_B) ? field_b : field_a;
            out_last = (phase == PH_B);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= PH_A;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            phase <= phase_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule
